// File: rtl/result_writeback_pkg.sv
// Shared definitions for the result write-back path.
// The destination codes match the operand-A select encoding so that the same
// 2-bit field can name a source on the read side and a target on the write side.
package result_writeback_pkg;

  // Write-back destination encoding (identical to the operand-A select)
  localparam logic [1:0] WB_DEST_RF  = 2'b00;
  localparam logic [1:0] WB_DEST_PC  = 2'b01;
  localparam logic [1:0] WB_DEST_CWP = 2'b10;
  localparam logic [1:0] WB_DEST_SR  = 2'b11;

  // Register-file index width (32 architectural registers, r0 hardwired)
  localparam int RF_ADDR_W = 5;

  // Write-back controller states
  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_RF_WRITE = 1'b1
  } wb_state_e;

  // A PC value is legal only when it is word aligned
  function automatic logic pc_aligned(input logic [1:0] lsbs);
    return (lsbs == 2'b00);
  endfunction

endpackage

// File: rtl/result_writeback_if.sv
// Write-back request channel plus register-file write port.
//
// Handshake rules:
//  - Request side: a request transfers on a rising Clk edge where
//    WB_Valid & WB_Ready are both 1. WB_Ready depends on controller state only,
//    never combinationally on WB_Valid.
//  - Register-file side: RF_We rises with RF_Addr/RF_Data stable and holds until
//    the edge on which RF_Ack=1 is seen; RF_Ack at any other time is ignored.
// The master modport is the environment (request producer and register file),
// the slave modport is the write-back block.
interface result_writeback_if #(
  parameter int DATA_W = 32
);
  import result_writeback_pkg::*;

  logic                 WB_Valid;
  logic                 WB_Ready;
  logic [1:0]           WB_Dest;
  logic [RF_ADDR_W-1:0] Rd;
  logic [DATA_W-1:0]    Result;
  logic                 RF_We;
  logic [RF_ADDR_W-1:0] RF_Addr;
  logic [DATA_W-1:0]    RF_Data;
  logic                 RF_Ack;

  modport master (
    output WB_Valid, WB_Dest, Rd, Result, RF_Ack,
    input  WB_Ready, RF_We, RF_Addr, RF_Data
  );

  modport slave (
    input  WB_Valid, WB_Dest, Rd, Result, RF_Ack,
    output WB_Ready, RF_We, RF_Addr, RF_Data
  );

endinterface

// File: rtl/result_writeback.sv
// Result write-back: returns an ALU result to the register file, PC, CWP or SR.
// PC, CWP and SR live here as architectural state; illegal PC (misaligned) and
// CWP (outside the implemented windows) values are dropped with an error pulse.
// Register-file writes go through a held RF_We/RF_Ack handshake.
module result_writeback
  import result_writeback_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int CWP_W    = 5,
  parameter int NWINDOWS = 32
) (
  input  logic               Clk,
  input  logic               Reset_n,
  result_writeback_if.slave  wb,
  output logic [DATA_W-1:0]  PC_Out,
  output logic [CWP_W-1:0]   CWP_Out,
  output logic [DATA_W-1:0]  SR_Out,
  output logic               Align_Error,
  output logic               Window_Error,
  output wb_state_e          Dbg_State
);

  // Window count widened by one bit so NWINDOWS == 2**CWP_W still fits
  localparam logic [CWP_W:0] NWIN = (CWP_W+1)'(NWINDOWS);

  wb_state_e            state_q, state_d;
  logic [RF_ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0]    rf_data_q, rf_data_d;
  logic [DATA_W-1:0]    pc_q, pc_d;
  logic [CWP_W-1:0]     cwp_q, cwp_d;
  logic [DATA_W-1:0]    sr_q, sr_d;
  logic                 align_err_q, align_err_d;
  logic                 window_err_q, window_err_d;
  logic                 cwp_legal;

  // A CWP value is legal when the upper Result bits are clear and the low
  // field names an implemented window
  assign cwp_legal = ({1'b0, wb.Result[CWP_W-1:0]} < NWIN) &&
                     (wb.Result[DATA_W-1:CWP_W] == '0);

  // Next-state and architectural updates; requests only accepted in IDLE
  always_comb begin
    state_d      = state_q;
    rf_addr_d    = rf_addr_q;
    rf_data_d    = rf_data_q;
    pc_d         = pc_q;
    cwp_d        = cwp_q;
    sr_d         = sr_q;
    align_err_d  = 1'b0;
    window_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wb.WB_Valid) begin
          case (wb.WB_Dest)
            WB_DEST_RF: begin
              // r0 is hardwired to zero: the request is consumed and dropped
              if (wb.Rd != '0) begin
                rf_addr_d = wb.Rd;
                rf_data_d = wb.Result;
                state_d   = ST_RF_WRITE;
              end
            end
            WB_DEST_PC: begin
              if (pc_aligned(wb.Result[1:0])) pc_d = wb.Result;
              else                            align_err_d = 1'b1;
            end
            WB_DEST_CWP: begin
              if (cwp_legal) cwp_d = wb.Result[CWP_W-1:0];
              else           window_err_d = 1'b1;
            end
            default: begin
              sr_d = wb.Result;
            end
          endcase
        end
      end
      ST_RF_WRITE: begin
        // Hold the write until the register file takes it; no timeout
        if (wb.RF_Ack) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; asynchronous reset aborts any pending register-file write
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= ST_IDLE;
      rf_addr_q    <= '0;
      rf_data_q    <= '0;
      pc_q         <= '0;
      cwp_q        <= '0;
      sr_q         <= '0;
      align_err_q  <= 1'b0;
      window_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rf_addr_q    <= rf_addr_d;
      rf_data_q    <= rf_data_d;
      pc_q         <= pc_d;
      cwp_q        <= cwp_d;
      sr_q         <= sr_d;
      align_err_q  <= align_err_d;
      window_err_q <= window_err_d;
    end
  end

  // Handshake outputs decode from state only, so reset drops RF_We at once
  assign wb.WB_Ready = (state_q == ST_IDLE);
  assign wb.RF_We    = (state_q == ST_RF_WRITE);
  assign wb.RF_Addr  = rf_addr_q;
  assign wb.RF_Data  = rf_data_q;

  assign PC_Out       = pc_q;
  assign CWP_Out      = cwp_q;
  assign SR_Out       = sr_q;
  assign Align_Error  = align_err_q;
  assign Window_Error = window_err_q;
  assign Dbg_State    = state_q;

endmodule

// File: tb/tb_result_writeback.sv
// Testbench for result_writeback: directed scenarios plus randomized traffic,
// checked against a behavioural model of the architectural state and a
// queue of expected register-file writes.
module tb_result_writeback;
  import result_writeback_pkg::*;

  localparam int DATA_W   = 32;
  localparam int CWP_W    = 5;
  localparam int NWINDOWS = 8;

  // ---------------- clock / reset ----------------
  logic              Clk;
  logic              Reset_n;
  logic [DATA_W-1:0] PC_Out;
  logic [CWP_W-1:0]  CWP_Out;
  logic [DATA_W-1:0] SR_Out;
  logic              Align_Error;
  logic              Window_Error;
  wb_state_e         Dbg_State;

  result_writeback_if #(.DATA_W(DATA_W)) wb_if ();

  result_writeback #(
    .DATA_W   (DATA_W),
    .CWP_W    (CWP_W),
    .NWINDOWS (NWINDOWS)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .wb           (wb_if.slave),
    .PC_Out       (PC_Out),
    .CWP_Out      (CWP_Out),
    .SR_Out       (SR_Out),
    .Align_Error  (Align_Error),
    .Window_Error (Window_Error),
    .Dbg_State    (Dbg_State)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- reference model / scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [RF_ADDR_W+DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] m_pc, m_sr;
  logic [CWP_W-1:0]  m_cwp;
  logic              m_align, m_window;

  task automatic model_reset();
    m_pc = '0; m_sr = '0; m_cwp = '0; m_align = 1'b0; m_window = 1'b0;
    exp_q.delete();
  endtask

  // What an accepted request does to the architectural state
  task automatic model_accept(input logic [1:0] dest, input logic [4:0] rd,
                              input logic [DATA_W-1:0] res);
    m_align  = 1'b0;
    m_window = 1'b0;
    if (dest == 2'd0) begin
      if (rd != 0) exp_q.push_back({rd, res});
    end else if (dest == 2'd1) begin
      if (res % 4 == 0) m_pc = res;
      else              m_align = 1'b1;
    end else if (dest == 2'd2) begin
      if (res < NWINDOWS) m_cwp = res[CWP_W-1:0];
      else                m_window = 1'b1;
    end else begin
      m_sr = res;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge with the block idle; returns at a falling edge
  // with the block idle again.
  task automatic issue(input logic [1:0] dest, input logic [4:0] rd,
                       input logic [DATA_W-1:0] res, input int ack_dly);
    logic [RF_ADDR_W+DATA_W-1:0] exp;
    checks++;
    if (wb_if.WB_Ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready: WB_Ready=%b, expected 1", wb_if.WB_Ready);
    end
    wb_if.WB_Valid = 1'b1;
    wb_if.WB_Dest  = dest;
    wb_if.Rd       = rd;
    wb_if.Result   = res;
    @(posedge Clk);
    model_accept(dest, rd, res);
    @(negedge Clk);
    wb_if.WB_Valid = 1'b0;
    wb_if.WB_Dest  = $urandom_range(0, 3);
    wb_if.Result   = $urandom;
    checks++;
    if ({PC_Out, CWP_Out, SR_Out, Align_Error, Window_Error} !==
        {m_pc, m_cwp, m_sr, m_align, m_window}) begin
      errors++;
      $display("FAIL arch_after_accept: pc=%h cwp=%0d sr=%h ae=%b we=%b, expected pc=%h cwp=%0d sr=%h ae=%b we=%b",
               PC_Out, CWP_Out, SR_Out, Align_Error, Window_Error,
               m_pc, m_cwp, m_sr, m_align, m_window);
    end
    if (dest == 2'd0 && rd != 0) begin
      exp = exp_q.pop_front();
      for (int i = 0; i <= ack_dly; i++) begin
        checks++;
        if ({wb_if.RF_We, wb_if.WB_Ready, wb_if.RF_Addr, wb_if.RF_Data} !== {2'b10, exp}) begin
          errors++;
          $display("FAIL rf_hold: we=%b rdy=%b addr=%0d data=%h, expected we=1 rdy=0 addr=%0d data=%h",
                   wb_if.RF_We, wb_if.WB_Ready, wb_if.RF_Addr, wb_if.RF_Data,
                   exp[DATA_W+RF_ADDR_W-1:DATA_W], exp[DATA_W-1:0]);
        end
        if (i < ack_dly) @(negedge Clk);
      end
      wb_if.RF_Ack = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      wb_if.RF_Ack = 1'b0;
      m_align  = 1'b0;
      m_window = 1'b0;
      checks++;
      if ({wb_if.RF_We, wb_if.WB_Ready, Align_Error, Window_Error} !== 4'b0100) begin
        errors++;
        $display("FAIL rf_release: we=%b rdy=%b ae=%b we_err=%b, expected 0 1 0 0",
                 wb_if.RF_We, wb_if.WB_Ready, Align_Error, Window_Error);
      end
    end else begin
      checks++;
      if ({wb_if.RF_We, wb_if.WB_Ready} !== 2'b01) begin
        errors++;
        $display("FAIL no_rf_write: we=%b rdy=%b, expected we=0 rdy=1",
                 wb_if.RF_We, wb_if.WB_Ready);
      end
    end
  endtask

  // One cycle with no request; error pulses must have cleared
  task automatic idle_cycle();
    @(negedge Clk);
    m_align  = 1'b0;
    m_window = 1'b0;
    checks++;
    if ({PC_Out, CWP_Out, SR_Out, Align_Error, Window_Error, wb_if.RF_We, wb_if.WB_Ready} !==
        {m_pc, m_cwp, m_sr, m_align, m_window, 2'b01}) begin
      errors++;
      $display("FAIL idle: pc=%h cwp=%0d sr=%h ae=%b we=%b rfwe=%b rdy=%b, expected pc=%h cwp=%0d sr=%h 0 0 0 1",
               PC_Out, CWP_Out, SR_Out, Align_Error, Window_Error, wb_if.RF_We,
               wb_if.WB_Ready, m_pc, m_cwp, m_sr);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    checks++;
    if ({PC_Out, CWP_Out, SR_Out, Align_Error, Window_Error, wb_if.RF_We,
         wb_if.RF_Addr, wb_if.RF_Data, wb_if.WB_Ready} !== {{(2*DATA_W+CWP_W+3+RF_ADDR_W+DATA_W){1'b0}}, 1'b1}
        || Dbg_State !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_values: pc=%h cwp=%0d sr=%h ae=%b we=%b rfwe=%b addr=%0d data=%h rdy=%b, expected all 0, rdy=1",
               PC_Out, CWP_Out, SR_Out, Align_Error, Window_Error, wb_if.RF_We,
               wb_if.RF_Addr, wb_if.RF_Data, wb_if.WB_Ready);
    end
    Reset_n = 1'b1;
    model_reset();
    idle_cycle();
  endtask

  task automatic test_rf_write();
    issue(2'd0, 5'd7, 32'hDEADBEEF, 3);
    // The release cycle above is the single idle bubble; a new write goes now
    issue(2'd0, 5'd9, 32'h0BADF00D, 0);
    idle_cycle();
  endtask

  task automatic test_r0();
    wb_if.RF_Ack = 1'b1;   // stray acknowledge while idle must be ignored
    issue(2'd0, 5'd0, 32'h12345678, 0);
    idle_cycle();
    idle_cycle();
    wb_if.RF_Ack = 1'b0;
  endtask

  task automatic test_pc();
    issue(2'd1, 5'd3, 32'h00001004, 0);
    issue(2'd1, 5'd3, 32'h00001006, 0);
    idle_cycle();
  endtask

  task automatic test_cwp();
    issue(2'd2, 5'd0, 32'd7, 0);
    issue(2'd2, 5'd0, 32'd8, 0);
    idle_cycle();
    issue(2'd2, 5'd0, 32'h00000020, 0);
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    issue(2'd3, 5'd0, 32'hA5A5A5A5, 0);
    issue(2'd1, 5'd0, 32'h00000010, 0);
    issue(2'd2, 5'd0, 32'd3, 0);
    idle_cycle();
  endtask

  task automatic test_random();
    logic [1:0]        dest;
    logic [4:0]        rd;
    logic [DATA_W-1:0] res;
    for (int n = 0; n < 80; n++) begin
      dest = 2'($urandom_range(0, 3));
      rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      res  = $urandom;
      if (dest == 2'd2 && $urandom_range(0, 3) != 0) res = $urandom_range(0, 12);
      if (dest == 2'd1 && $urandom_range(0, 1) == 0) res = res & ~32'd3;
      issue(dest, rd, res, $urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) idle_cycle();
    end
  endtask

  task automatic test_reset_mid();
    issue(2'd3, 5'd0, 32'h5A5A5A5A, 0);
    issue(2'd1, 5'd0, 32'h00000040, 0);
    issue(2'd2, 5'd0, 32'd5, 0);
    wb_if.WB_Valid = 1'b1;
    wb_if.WB_Dest  = 2'd0;
    wb_if.Rd       = 5'd12;
    wb_if.Result   = 32'hCAFEF00D;
    @(posedge Clk);
    @(negedge Clk);
    wb_if.WB_Valid = 1'b0;
    checks++;
    if (wb_if.RF_We !== 1'b1) begin
      errors++;
      $display("FAIL mid_rf_started: RF_We=%b, expected 1", wb_if.RF_We);
    end
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if ({PC_Out, CWP_Out, SR_Out, Align_Error, Window_Error, wb_if.RF_We,
         wb_if.RF_Addr, wb_if.RF_Data, wb_if.WB_Ready} !== {{(2*DATA_W+CWP_W+3+RF_ADDR_W+DATA_W){1'b0}}, 1'b1}) begin
      errors++;
      $display("FAIL mid_reset_async: pc=%h cwp=%0d sr=%h rfwe=%b addr=%0d data=%h rdy=%b, expected all 0, rdy=1",
               PC_Out, CWP_Out, SR_Out, wb_if.RF_We, wb_if.RF_Addr, wb_if.RF_Data,
               wb_if.WB_Ready);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
    idle_cycle();
    idle_cycle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    wb_if.WB_Valid = 1'b0;
    wb_if.WB_Dest  = 2'd0;
    wb_if.Rd       = 5'd0;
    wb_if.Result   = '0;
    wb_if.RF_Ack   = 1'b0;
    Reset_n        = 1'b0;
    model_reset();
    test_reset();
    test_rf_write();
    test_r0();
    test_pc();
    test_cwp();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
